// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: shared defaults and types for the instruction-memory responder
//   IMEM_DEPTH : default number of outstanding fetch transactions
//   imem_rsp_t : one queued response entry {rdata, err}
package cv32e40p_pkg;
   localparam int IMEM_DEPTH = 2;
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } imem_rsp_t;
endpackage

// File: rtl/cv32e40p_imem_responder_if.sv
// cv32e40p_imem_responder_if: OBI instruction fetch bus between initiator and responder
//   req/addr       : address phase, driven by the master
//   gnt            : grant, driven by the slave
//   rvalid/rdata/err : response phase, driven by the slave
interface cv32e40p_imem_responder_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;
   modport master (output req, addr, input gnt, rvalid, rdata, err);
   modport slave (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/cv32e40p_fifo.sv
// cv32e40p_fifo: synchronous FIFO with simultaneous push/pop and first-word-fall-through read
//   clk, rst_n : clock, synchronous active-low reset (flushes contents)
//   push_i, wdata_i : write strobe and data
//   pop_i      : drop the head entry
//   empty_o, rdata_o : empty flag and head entry
module cv32e40p_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic             empty_o,
   output logic [WIDTH-1:0] rdata_o
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wp_q, rp_q;
   logic [CW-1:0]    cnt_q;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
   endfunction
   assign empty_o = cnt_q == '0;
   assign rdata_o = mem_q[rp_q];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wp_q] <= wdata_i;
            wp_q        <= nxt(wp_q);
         end
         if (pop_i) rp_q <= nxt(rp_q);
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end
endmodule

// File: rtl/cv32e40p_imem_responder.sv
// cv32e40p_imem_responder: OBI instruction-memory responder in front of a synchronous SRAM
//   clk, rst_n   : clock, synchronous active-low reset
//   instr        : OBI fetch bus (slave side)
//   gnt_stall_i  : suppress grants
//   rsp_stall_i  : suppress responses
//   mem_req_o, mem_addr_o, mem_rdata_i : SRAM read port, data one cycle after request
module cv32e40p_imem_responder import cv32e40p_pkg::*; #(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int          MEM_WORDS = 4096,
   parameter int          DEPTH     = IMEM_DEPTH,
   localparam int         AW        = $clog2(MEM_WORDS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   cv32e40p_imem_responder_if.slave   instr,
   input  logic                       gnt_stall_i,
   input  logic                       rsp_stall_i,
   output logic                       mem_req_o,
   output logic [AW-1:0]              mem_addr_o,
   input  logic [31:0]                mem_rdata_i
);
   localparam int          CW    = $clog2(DEPTH + 1);
   localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 2;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_v_q, pend_err_q;
   logic          in_range, gnt, rvalid, empty, push, pop;
   logic [32:0]   off;
   imem_rsp_t     byp, head;
   // addresses below the base wrap to a huge offset, so one compare covers both bounds
   assign off      = {1'b0, instr.addr} - {1'b0, ADDR_BASE};
   assign in_range = off < LIMIT;
   // credits only count the registered occupancy; a same-cycle response frees nothing
   assign gnt      = rst_n & instr.req & ~gnt_stall_i & (cnt_q < CW'(DEPTH));
   assign rvalid   = rst_n & ~rsp_stall_i & (pend_v_q | ~empty);
   assign pop      = rvalid & ~empty;
   // the pending response bypasses the queue only when nothing older is waiting
   assign push     = rst_n & pend_v_q & ~(rvalid & empty);
   assign byp      = {pend_err_q ? 32'h0 : mem_rdata_i, pend_err_q};
   assign cnt_d    = cnt_q + CW'(gnt) - CW'(rvalid);
   assign mem_req_o    = gnt & in_range;
   assign mem_addr_o   = off[AW+1:2];
   assign instr.gnt    = gnt;
   assign instr.rvalid = rvalid;
   assign instr.rdata  = rvalid ? (empty ? byp.rdata : head.rdata) : 32'h0;
   assign instr.err    = rvalid & (empty ? byp.err : head.err);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         pend_v_q   <= 1'b0;
         pend_err_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         pend_v_q   <= gnt;
         pend_err_q <= gnt & ~in_range;
      end
   end
   cv32e40p_fifo #(.DEPTH(DEPTH), .WIDTH($bits(imem_rsp_t))) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (byp),
      .pop_i   (pop),
      .empty_o (empty),
      .rdata_o (head)
   );
endmodule

// File: tb/tb_cv32e40p_imem_responder.sv
// tb_cv32e40p_imem_responder: directed self-checking bench with a synchronous SRAM model
module tb_cv32e40p_imem_responder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gnt_stall = 1'b0;
   logic        rsp_stall = 1'b0;
   logic        mem_req;
   logic [11:0] mem_addr;
   logic [31:0] mem_rdata = 32'h0;
   logic [31:0] mem [4096];
   int          errs = 0;
   int          checks = 0;
   cv32e40p_imem_responder_if bus();
   cv32e40p_imem_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (bus.slave),
      .gnt_stall_i (gnt_stall),
      .rsp_stall_i (rsp_stall),
      .mem_req_o   (mem_req),
      .mem_addr_o  (mem_addr),
      .mem_rdata_i (mem_rdata)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (mem_req) mem_rdata <= mem[mem_addr];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drv(input logic r, input logic [31:0] a, input logic gs, input logic rs);
      bus.req   = r;
      bus.addr  = a;
      gnt_stall = gs;
      rsp_stall = rs;
      #2;
   endtask
   task automatic rsp(input string tag, input logic v, input logic [31:0] d, input logic e);
      chk({tag, ".rvalid"}, 32'(bus.rvalid), 32'(v));
      chk({tag, ".rdata"}, bus.rdata, d);
      chk({tag, ".err"}, 32'(bus.err), 32'(e));
   endtask
   task automatic req_chk(input string tag, input logic g, input logic m, input logic [11:0] a);
      chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
      chk({tag, ".mem_req"}, 32'(mem_req), 32'(m));
      if (m) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(a));
   endtask
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      bus.req  = 1'b0;
      bus.addr = 32'h0;
      tick();
      drv(1, 32'h0, 0, 0);
      req_chk("rst", 0, 0, 0);
      rsp("rst", 0, 0, 0);
      tick();
      rst_n = 1'b1;
      drv(1, 32'h0, 0, 0); req_chk("b2b0", 1, 1, 12'h0); rsp("b2b0", 0, 0, 0); tick();
      drv(1, 32'h4, 0, 0); req_chk("b2b1", 1, 1, 12'h1); rsp("b2b1", 1, 32'hC0DE_0000, 0); tick();
      drv(1, 32'h8, 0, 0); req_chk("b2b2", 1, 1, 12'h2); rsp("b2b2", 1, 32'hC0DE_0001, 0); tick();
      drv(0, 32'h0, 0, 0); req_chk("b2b3", 0, 0, 0); rsp("b2b3", 1, 32'hC0DE_0002, 0); tick();
      drv(0, 32'h0, 0, 0); req_chk("idle", 0, 0, 0); rsp("idle", 0, 0, 0); tick();
      drv(1, 32'h10, 0, 0); req_chk("stl0", 1, 1, 12'h4); tick();
      drv(1, 32'h14, 0, 1); req_chk("stl1", 1, 1, 12'h5); rsp("stl1", 0, 0, 0); tick();
      drv(1, 32'h18, 0, 1); req_chk("stl2", 0, 0, 0); rsp("stl2", 0, 0, 0); tick();
      drv(1, 32'h18, 0, 1); req_chk("stl3", 0, 0, 0); rsp("stl3", 0, 0, 0); tick();
      drv(1, 32'h18, 0, 0); req_chk("stl4", 0, 0, 0); rsp("stl4", 1, 32'hC0DE_0004, 0); tick();
      drv(1, 32'h18, 0, 0); req_chk("stl5", 1, 1, 12'h6); rsp("stl5", 1, 32'hC0DE_0005, 0); tick();
      drv(0, 32'h0, 0, 0); req_chk("stl6", 0, 0, 0); rsp("stl6", 1, 32'hC0DE_0006, 0); tick();
      drv(1, 32'h3FFC, 0, 0); req_chk("top", 1, 1, 12'hFFF); rsp("top", 0, 0, 0); tick();
      drv(1, 32'h4000, 0, 0); req_chk("oor", 1, 0, 0); rsp("top", 1, 32'hC0DE_0FFF, 0); tick();
      drv(0, 32'h0, 0, 0); rsp("oor", 1, 32'h0, 1); tick();
      drv(1, 32'h10, 0, 0); req_chk("mix0", 1, 1, 12'h4); rsp("mix0", 0, 0, 0); tick();
      drv(1, 32'h8000_0000, 0, 0); req_chk("mix1", 1, 0, 0); rsp("mix1", 1, 32'hC0DE_0004, 0); tick();
      drv(1, 32'h14, 0, 0); req_chk("mix2", 1, 1, 12'h5); rsp("mix2", 1, 32'h0, 1); tick();
      drv(0, 32'h0, 0, 0); rsp("mix3", 1, 32'hC0DE_0005, 0); tick();
      for (int i = 0; i < 4; i++) begin
         drv(1, 32'h20, 1, 0); req_chk($sformatf("gst%0d", i), 0, 0, 0); tick();
      end
      drv(1, 32'h20, 0, 0); req_chk("gst4", 1, 1, 12'h8); tick();
      drv(0, 32'h0, 0, 0); rsp("gst5", 1, 32'hC0DE_0008, 0); tick();
      drv(1, 32'h0, 0, 0); req_chk("rr0", 1, 1, 12'h0); tick();
      drv(1, 32'h4, 0, 1); req_chk("rr1", 1, 1, 12'h1); rsp("rr1", 0, 0, 0); tick();
      rst_n = 1'b0;
      drv(1, 32'h8, 0, 0); req_chk("rr2", 0, 0, 0); rsp("rr2", 0, 0, 0); tick();
      rst_n = 1'b1;
      drv(0, 32'h0, 0, 0); rsp("rr3", 0, 0, 0); tick();
      drv(1, 32'h8, 0, 0); req_chk("rr4", 1, 1, 12'h2); rsp("rr4", 0, 0, 0); tick();
      drv(1, 32'hC, 0, 1); req_chk("rr5", 1, 1, 12'h3); rsp("rr5", 0, 0, 0); tick();
      drv(0, 32'h0, 0, 0); rsp("rr6", 1, 32'hC0DE_0002, 0); tick();
      drv(0, 32'h0, 0, 0); rsp("rr7", 1, 32'hC0DE_0003, 0); tick();
      drv(0, 32'h0, 0, 0); rsp("rr8", 0, 0, 0); chk("rr8.mem_req", 32'(mem_req), 32'h0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/cv32e40p_imem_responder.md
CV32E40P_IMEM_RESPONDER -- requirements
Module: cv32e40p_imem_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000, byte base address of the backing instruction memory.
REQ-002 SHALL have parameter MEM_WORDS, default 4096, backing memory depth in 32-bit words; AW = $clog2(MEM_WORDS).
REQ-003 SHALL have parameter DEPTH, default 2, maximum outstanding (granted, not yet responded) transactions.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk, rst_n.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 instr_req_i  input  1  OBI address-phase request from the fetch initiator.
REQ-008 instr_addr_i  input  32  fetch byte address, word-aligned.
REQ-009 instr_gnt_o  output  1  OBI grant.
REQ-010 instr_rvalid_o  output  1  OBI response valid; the initiator always accepts it.
REQ-011 instr_rdata_o  output  32  response data.
REQ-012 instr_err_o  output  1  response bus error, qualified by instr_rvalid_o.
REQ-013 gnt_stall_i  input  1  when high, forces instr_gnt_o low (models a busy memory).
REQ-014 rsp_stall_i  input  1  when high, forces instr_rvalid_o low (models a slow response).
REQ-015 mem_req_o  output  1  synchronous SRAM read enable.
REQ-016 mem_addr_o  output  AW  SRAM word address.
REQ-017 mem_rdata_i  input  32  SRAM read data, valid one cycle after mem_req_o.

Function
REQ-018 instr_gnt_o SHALL be instr_req_i & ~gnt_stall_i & (outstanding < DEPTH), combinational; a response in the same cycle SHALL NOT free a credit early.
REQ-019 outstanding SHALL increment on grant, decrement on instr_rvalid_o, be unchanged when both occur, and never exceed DEPTH or drop below 0.
REQ-020 In-range grant (ADDR_BASE <= addr < ADDR_BASE+4*MEM_WORDS): mem_req_o=1 and mem_addr_o=(addr-ADDR_BASE)>>2 in the grant cycle.
REQ-021 Out-of-range grant: mem_req_o=0; the response SHALL carry instr_err_o=1 and instr_rdata_o=0.
REQ-022 A one-entry pending stage (valid, err flag) SHALL capture each grant; in the following cycle (T+1) its response is resolved.
REQ-023 At T+1, if the response FIFO is empty and rsp_stall_i=0, SHALL drive instr_rvalid_o=1 with mem_rdata_i (or 0/err) directly (bypass, latency 1).
REQ-024 At T+1 otherwise, SHALL push {rdata, err} into the response FIFO (DEPTH entries).
REQ-025 When the FIFO is non-empty and rsp_stall_i=0, SHALL drive instr_rvalid_o=1 from the FIFO head and pop it; the bypass is blocked in that cycle.
REQ-026 Responses SHALL be returned strictly in grant order; at most one rvalid per cycle.
REQ-027 FIFO push while full SHALL be impossible by construction (credit rule REQ-018); simultaneous push and pop SHALL be supported.
REQ-028 When idle, instr_rvalid_o=0, instr_err_o=0, instr_rdata_o=0 and mem_req_o=0.

Reset
REQ-029 While rst_n=0 at a clock edge: outstanding=0, pending stage invalid, FIFO empty; instr_gnt_o, instr_rvalid_o, instr_err_o and mem_req_o SHALL be 0, and instr_rdata_o SHALL be 0.
REQ-030 Reset mid-transaction SHALL discard all in-flight responses; no rvalid SHALL follow for transactions granted before reset.

Structure
REQ-031 The DEPTH default and any response-entry struct ({rdata, err}) SHALL live in cv32e40p_pkg.
REQ-032 The response queue SHALL be one instance of the existing cv32e40p_fifo sub-module; the remaining logic (credit counter, pending stage, range check) stays in this module.

Verification
REQ-033 Back-to-back requests to 0x0, 0x4, 0x8, no stalls -> grants every cycle, rvalid each one cycle later, data mem[0], mem[1], mem[2].
REQ-034 Two grants, then rsp_stall_i=1 for 3 cycles -> third request not granted (outstanding=2); after the stall drops, the two responses return in order on consecutive cycles, then the third request is granted.
REQ-035 Request to ADDR_BASE+4*MEM_WORDS -> granted, mem_req_o=0, next cycle rvalid=1, err=1, rdata=0.
REQ-036 Interleave in-range 0x10, out-of-range, in-range 0x14 -> responses in order: mem[4]/err0, 0/err1, mem[5]/err0.
REQ-037 gnt_stall_i=1 with req held for 4 cycles -> no grant, no mem_req_o; grant on the first cycle the stall is low.
REQ-038 Assert rst_n=0 for one cycle with 2 outstanding -> no rvalid afterwards, outstanding=0, the next request is granted immediately.
